// File: rtl/match_reporter_pkg.sv
// Shared types and default sizing for the match reporter and its event queue.
package match_reporter_pkg;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int TS_WIDTH_DEF   = 32;
  localparam int CNT_W          = 16;

  typedef enum logic {
    ARMED = 1'b0,
    HOLD  = 1'b1
  } state_t;
endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through event queue; a push into a full queue is taken when a pop coincides.
module event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic [AW:0]      cnt_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    cnt_nxt = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Flags are registered from the next count so they never depend on this cycle's inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/match_reporter.sv
// Timestamps accepted match pulses, enforces a sample holdoff between events,
// queues the events and keeps sticky overflow plus saturating statistics.
module match_reporter
  import match_reporter_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TS_WIDTH   = TS_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rxstrobe,
  input  logic                valid,
  input  logic                match,
  input  logic                enable,
  input  logic [CNT_W-1:0]    holdoff,
  input  logic                clr,
  output logic                ev_rdy,
  output logic [TS_WIDTH-1:0] ev_data,
  input  logic                ev_ack,
  output logic                overflow,
  output logic [CNT_W-1:0]    match_count,
  output logic [CNT_W-1:0]    drop_count
);
  state_t              state;
  logic [TS_WIDTH-1:0] ts;
  logic [CNT_W-1:0]    hold_cnt;
  logic                hit;
  logic                accept;
  logic                drop;
  logic                pop_eff;
  logic                lost;
  logic                fifo_empty;
  logic                fifo_full;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign hit     = valid & match;
  assign accept  = hit & enable & (state == ARMED);
  assign drop    = hit & enable & (state == HOLD);
  assign pop_eff = ev_ack & ~fifo_empty;
  assign lost    = accept & fifo_full & ~pop_eff;
  assign ev_rdy  = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ts          <= '0;
      state       <= ARMED;
      hold_cnt    <= '0;
      overflow    <= 1'b0;
      match_count <= '0;
      drop_count  <= '0;
    end else begin
      if (rxstrobe) ts <= ts + 1'b1;

      // A fresh load wins over the strobe-driven countdown.
      if (accept) begin
        hold_cnt <= holdoff;
        state    <= (holdoff != '0) ? HOLD : ARMED;
      end else if (state == HOLD && rxstrobe) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt < CNT_W'(2)) state <= ARMED;
      end

      if (clr)         match_count <= '0;
      else if (accept) match_count <= sat_inc(match_count);

      if (clr)       drop_count <= '0;
      else if (drop) drop_count <= sat_inc(drop_count);

      if (lost)     overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

  event_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(TS_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (accept),
    .pop  (ev_ack),
    .din  (ts),
    .dout (ev_data),
    .empty(fifo_empty),
    .full (fifo_full)
  );
endmodule

// File: tb/tb_match_reporter.sv
// Scoreboard bench for match_reporter: a queue-based reference model predicts events
// and statistics, a monitor retires events on each ev_rdy/ev_ack handshake.
module tb_match_reporter;
  localparam int DEPTH = 8;
  localparam int TSW   = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           rxstrobe = 1'b0;
  logic           valid = 1'b0;
  logic           match = 1'b0;
  logic           enable = 1'b0;
  logic [15:0]    holdoff = '0;
  logic           clr = 1'b0;
  logic           ev_ack = 1'b0;
  logic           ev_rdy;
  logic [TSW-1:0] ev_data;
  logic           overflow;
  logic [15:0]    match_count;
  logic [15:0]    drop_count;

  int vectors = 0;
  int fails = 0;

  match_reporter #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clk(clk), .reset(reset), .rxstrobe(rxstrobe), .valid(valid), .match(match),
    .enable(enable), .holdoff(holdoff), .clr(clr), .ev_rdy(ev_rdy), .ev_data(ev_data),
    .ev_ack(ev_ack), .overflow(overflow), .match_count(match_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: the queue is the expected FIFO contents, head first.
  logic [TSW-1:0] q[$];
  logic [TSW-1:0] m_ts;
  int             m_hold;
  int             m_mcnt;
  int             m_dcnt;
  logic           m_ovf;
  bit             model_on = 0;

  always begin
    @(negedge clk);
    #1;
    if (model_on) begin
      chk("ev_rdy", ev_rdy, q.size() != 0);
      if (q.size() != 0) chk("ev_data_head", ev_data, q[0]);
      chk("overflow", overflow, m_ovf);
      chk("match_count", match_count, m_mcnt);
      chk("drop_count", drop_count, m_dcnt);
    end
    if (!reset) begin
      q.delete();
      m_ts = '0; m_hold = 0; m_mcnt = 0; m_dcnt = 0; m_ovf = 1'b0;
      model_on = 1;
    end else if (model_on) begin
      bit h, acc, drp, pop, lost;
      h    = valid && match && enable;
      acc  = h && (m_hold == 0);
      drp  = h && (m_hold != 0);
      pop  = ev_ack && (q.size() != 0);
      lost = 0;
      if (acc) begin
        if (q.size() >= DEPTH && !pop) lost = 1;
        else q.push_back(m_ts);
        m_hold = holdoff;
      end else if (m_hold > 0 && rxstrobe) begin
        m_hold = m_hold - 1;
      end
      if (clr) m_mcnt = 0;
      else if (acc && m_mcnt < 65535) m_mcnt = m_mcnt + 1;
      if (clr) m_dcnt = 0;
      else if (drp && m_dcnt < 65535) m_dcnt = m_dcnt + 1;
      if (lost) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (rxstrobe) m_ts = m_ts + 1'b1;
    end
  end

  // Monitor: every handshake the DUT will honour retires the expected head.
  always begin
    @(negedge clk);
    #2;
    if (model_on && reset && ev_rdy && ev_ack) begin
      if (q.size() == 0) chk("pop_unexpected", ev_rdy, 1'b0);
      else begin
        logic [TSW-1:0] exp;
        exp = q.pop_front();
        chk("ev_data_pop", ev_data, exp);
      end
    end
  end

  task automatic cyc(input logic s, input logic h, input logic a = 1'b0, input logic c = 1'b0);
    @(negedge clk);
    rxstrobe = s; valid = h; match = h; ev_ack = a; clr = c;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(0, 0);
    cyc(0, 0);
    reset = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_ev_rdy", ev_rdy, 1'b0);
    chk("rst_ev_data", ev_data, '0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_match_count", match_count, '0);
    chk("rst_drop_count", drop_count, '0);

    // Timestamp capture with no holdoff
    enable = 1'b1; holdoff = 16'd0;
    repeat (5) cyc(1, 0);
    cyc(0, 1);
    cyc(0, 0);
    chk("t1_ev_rdy", ev_rdy, 1'b1);
    chk("t1_ev_data", ev_data, 10'd5);
    chk("t1_match_count", match_count, 16'd1);

    // Holdoff of 3 samples: hits at 10,11,12,14
    do_reset();
    holdoff = 16'd3;
    repeat (10) cyc(1, 0);
    cyc(1, 1); cyc(1, 1); cyc(1, 1); cyc(1, 0); cyc(1, 1);
    cyc(0, 0);
    chk("t2_drop_count", drop_count, 16'd2);
    chk("t2_match_count", match_count, 16'd2);
    chk("t2_first", ev_data, 10'd10);
    cyc(0, 0, 1);
    cyc(0, 0);
    chk("t2_second", ev_data, 10'd14);
    cyc(0, 0, 1);
    cyc(0, 0);
    chk("t2_drained", ev_rdy, 1'b0);

    // Overflow on the 9th accepted hit
    do_reset();
    holdoff = 16'd0;
    repeat (9) cyc(0, 1);
    cyc(0, 0);
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_match_count", match_count, 16'd9);
    chk("t3_head", ev_data, 10'd0);
    cyc(0, 0, 0, 1);
    cyc(0, 0);
    chk("t3_clr_overflow", overflow, 1'b0);
    chk("t3_clr_match", match_count, 16'd0);

    // Full queue with coincident pop accepts the push
    do_reset();
    repeat (8) cyc(1, 1);
    cyc(1, 1, 1);
    cyc(0, 0);
    chk("t3b_overflow", overflow, 1'b0);
    chk("t3b_match_count", match_count, 16'd9);
    chk("t3b_head", ev_data, 10'd1);

    // Disabled reporting ignores hits
    do_reset();
    enable = 1'b0;
    repeat (4) cyc(1, 1);
    cyc(0, 0);
    chk("t4_ev_rdy", ev_rdy, 1'b0);
    chk("t4_match_count", match_count, 16'd0);
    chk("t4_drop_count", drop_count, 16'd0);
    enable = 1'b1;
    cyc(0, 1);
    cyc(0, 0);
    chk("t4_one_event", ev_data, 10'd4);
    cyc(0, 0, 1);
    cyc(0, 0);
    chk("t4_single", ev_rdy, 1'b0);

    // Timestamp wrap
    do_reset();
    repeat ((1 << TSW) - 1) cyc(1, 0);
    cyc(1, 1);
    cyc(0, 1);
    cyc(0, 0);
    chk("t5_max_ts", ev_data, 10'h3FF);
    cyc(0, 0, 1);
    cyc(0, 0);
    chk("t5_wrapped", ev_data, 10'h000);
    cyc(0, 0, 1);

    // Reset while holding with three queued events
    do_reset();
    cyc(1, 1); cyc(1, 1);
    holdoff = 16'd10;
    cyc(1, 1);
    cyc(1, 0); cyc(1, 0);
    reset = 1'b0;
    cyc(0, 0);
    reset = 1'b1;
    chk("t6_ev_rdy", ev_rdy, 1'b0);
    cyc(1, 0); cyc(1, 0);
    cyc(0, 1);
    cyc(0, 0);
    chk("t6_ev_rdy_after", ev_rdy, 1'b1);
    chk("t6_ts_from_zero", ev_data, 10'd2);
    chk("t6_match_count", match_count, 16'd1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i % 200 == 0) holdoff = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      rxstrobe = ($urandom_range(0, 2) == 0);
      valid    = ($urandom_range(0, 3) == 0);
      match    = ($urandom_range(0, 1) == 0);
      ev_ack   = ($urandom_range(0, 3) == 0);
      clr      = ($urandom_range(0, 59) == 0);
      reset    = ($urandom_range(0, 699) != 0);
    end
    reset = 1'b1;
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/match_reporter.md
# match_reporter

Downstream of the match filter, `match_reporter` consumes its `valid`/`match` result pulses. It timestamps each accepted match with a free-running sample counter and applies a programmable holdoff, so one preamble produces one event. Accepted events are queued in a small FWFT FIFO and drained by the inband packet builder through a ready/ack handshake. Sticky overflow and match statistics are exposed for the status registers.

## Interface
- `FIFO_DEPTH`, 8: event queue depth; must be a power of two and at least 2
- `TS_WIDTH`, 32: timestamp/sample-counter width
- `clk`  in  1  system clock; the only clock
- `reset`  in  1  synchronous, active-low reset
- `rxstrobe`  in  1  one-cycle sample strobe, the same one that drives the match filter
- `valid`  in  1  match-filter result valid, one-cycle pulse
- `match`  in  1  match-filter decision; sampled only when `valid`=1
- `enable`  in  1  arms event reporting; held static by the control register
- `holdoff`  in  16  number of samples suppressed after an accepted match
- `clr`  in  1  one-cycle pulse; clears `match_count`, `drop_count` and `overflow`
- `ev_rdy`  out  1  FIFO non-empty
- `ev_data`  out  TS_WIDTH  timestamp at the FIFO head
- `ev_ack`  in  1  pops the head; honoured only when `ev_rdy`=1
- `overflow`  out  1  sticky; set when an accepted match is lost because the FIFO is full
- `match_count`  out  16  accepted matches, saturating at 0xFFFF
- `drop_count`  out  16  matches suppressed by holdoff, saturating at 0xFFFF

## Operation
- `ts`: a TS_WIDTH counter that increments by 1 on each `rxstrobe` and wraps from all-ones to 0.
- Hit condition: `hit = valid & match`.
- FSM has two states.
  - ARMED: if `hit & enable`, the match is accepted.
    - `ts` is captured and pushed into the FIFO.
    - `match_count` increments.
    - `hold_cnt` loads `holdoff`.
    - The FSM moves to HOLD if `holdoff`≠0; otherwise it stays in ARMED.
  - HOLD: `hold_cnt` decrements on each `rxstrobe`. When it decrements from 1 to 0, the FSM returns to ARMED on the next cycle.
    - A `hit` in HOLD with `enable`=1 is not pushed; `drop_count` increments instead.
- If `enable`=0, hits are ignored and no counter changes. A HOLD already in progress continues to count down.
- Captured timestamp: the value of `ts` in the `hit` cycle, before any increment from a coincident `rxstrobe`.
- FIFO full at an accepted push:
  - The event is discarded and `overflow` is set.
  - `match_count` still increments and the FSM still enters HOLD.
- Push and pop in the same cycle:
  - When full, both take effect, and the new event is stored without overflow.
  - When empty, the push takes effect and the pop is ignored, because `ev_rdy`=0.
- `ev_ack` while `ev_rdy`=0 is ignored.
- `clr` coincident with an accepted match: the clear wins, so `match_count` reads 0 afterwards. The same rule applies to a coincident drop for `drop_count`. `overflow` is cleared unless the same cycle sets it, in which case set wins.
- Width rule: `hold_cnt` is 16 bits, and its load takes priority over its decrement.

## Timing
- Reset (`reset`=0 at a clock edge) produces:
  - `ts`=0, FSM=ARMED, `hold_cnt`=0
  - FIFO empty, so `ev_rdy`=0, `ev_data`=0
  - `overflow`=0, `match_count`=0, `drop_count`=0
- Reset mid-operation discards queued events and any HOLD in progress.
- Latency: a `hit` at cycle N into an empty FIFO gives `ev_rdy`=1 and valid `ev_data` at N+1.
- FWFT: `ev_data` is valid whenever `ev_rdy`=1. After `ev_ack` at cycle M, the next head (or `ev_rdy`=0) appears at M+1.
- With `holdoff`=H, a hit is next accepted no earlier than H `rxstrobe`s after the accepting hit, plus 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `match_reporter_pkg` holds:
  - FSM state enum (ARMED, HOLD)
  - default `FIFO_DEPTH`/`TS_WIDTH` constants
  - counter width constant (16)
- Sub-module `event_fifo`: synchronous FWFT FIFO with parameterized depth and width.
  - Ports: push, pop, din, dout, empty, full.
  - Full-with-simultaneous-pop accepts the push.
- Top level holds the timestamp counter, FSM, holdoff counter and statistics.

## Test plan
- Reset, then 5 `rxstrobe`s, then a hit with `holdoff`=0 → `ev_rdy` rises 1 cycle later with `ev_data`=5, `match_count`=1.
- `holdoff`=3; hits at samples 10, 11, 12, 14 → events 10 and 14 queued, `drop_count`=2.
- `FIFO_DEPTH`=8, no acks, 9 accepted hits → 8 events held, `overflow`=1, `match_count`=9. The 9th hit again coincident with `ev_ack` (fresh run) → no overflow.
- `enable`=0 with 4 hits → no events, all counters 0. Set `enable`=1, then 1 hit → exactly 1 event.
- `ts` preset near wrap: hit at `ts`=0xFFFFFFFF with coincident `rxstrobe` → `ev_data`=0xFFFFFFFF, and the next event shows wrapped values.
- Reset asserted while in HOLD with 3 queued events → `ev_rdy`=0, FSM armed, and the next hit is reported with `ts` counted from 0.
